// File: rtl/psg_pkg.sv
// Shared protocol constants and types for the PSG host register interface.
// Byte layout: bit 7 latch flag, bits 6:5 channel, bit 4 register type.
package psg_pkg;

  localparam int LATCH_BIT = 7;
  localparam int CH_MSB    = 6;
  localparam int CH_LSB    = 5;
  localparam int TYPE_BIT  = 4;

  typedef enum logic {
    REG_TONE   = 1'b0,
    REG_VOLUME = 1'b1
  } reg_type_e;

  localparam logic [1:0] NOISE_CH    = 2'd3;
  localparam logic [3:0] ATTN_SILENT = 4'hF;

  typedef struct packed {
    logic [1:0] ch;
    reg_type_e  kind;
  } reg_ptr_t;

  // The tone slot of channel 3 is the noise control register.
  function automatic logic is_noise(input reg_ptr_t p);
    return (p.ch == NOISE_CH) && (p.kind == REG_TONE);
  endfunction

endpackage

// File: rtl/psg_ready_timer.sv
// READY handshake timer: after an accepted byte, ready is held low for
// exactly READY_CYCLES cycles, then the block returns to IDLE.
module psg_ready_timer
  import psg_pkg::*;
#(
  parameter int READY_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic accept,
  output logic ready
);

  localparam int CW = (READY_CYCLES > 1) ? $clog2(READY_CYCLES) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]    r_state;
  logic [CW-1:0] r_count;
  logic          r_ready;

  // Loading READY_CYCLES-1 and leaving on the zero count gives a low time
  // of exactly READY_CYCLES cycles after the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (accept) begin
            r_count <= CW'(READY_CYCLES - 1);
            r_state <= ST_BUSY;
            r_ready <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (r_count == '0) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready = r_ready;

endmodule

// File: rtl/psg_register_control.sv
// Host-side register file for the SN76489-style PSG: decodes latch/data
// bytes into tone periods, attenuations and noise control, with READY pacing.
module psg_register_control
  import psg_pkg::*;
#(
  parameter int COUNTER_BITS = 10,
  parameter int ATTN_BITS    = 4,
  parameter int READY_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              data,
  input  logic                    wr_en,
  output logic                    ready,
  output logic [COUNTER_BITS-1:0] tone_freq0,
  output logic [COUNTER_BITS-1:0] tone_freq1,
  output logic [COUNTER_BITS-1:0] tone_freq2,
  output logic [ATTN_BITS-1:0]    attn0,
  output logic [ATTN_BITS-1:0]    attn1,
  output logic [ATTN_BITS-1:0]    attn2,
  output logic [ATTN_BITS-1:0]    attn3,
  output logic [2:0]              noise_control,
  output logic                    reset_lfsr
);

  logic                    w_ready;
  logic                    w_accept;
  logic                    w_is_latch;
  logic                    w_noise_hit;
  reg_ptr_t                w_ptr;
  reg_ptr_t                r_ptr;
  logic [2:0]              r_noise;
  logic                    r_reset_lfsr;
  logic [COUNTER_BITS-1:0] w_tone [3];
  logic [ATTN_BITS-1:0]    w_attn [4];

  psg_ready_timer #(
    .READY_CYCLES(READY_CYCLES)
  ) u_ready_timer (
    .clk   (clk),
    .reset (reset),
    .accept(w_accept),
    .ready (w_ready)
  );

  assign w_accept   = wr_en & w_ready;
  assign w_is_latch = data[LATCH_BIT];

  // A latch byte retargets the write immediately; a data byte uses the
  // pointer left by the previous latch.
  always_comb begin
    w_ptr = r_ptr;
    if (w_is_latch) begin
      w_ptr.ch   = data[CH_MSB:CH_LSB];
      w_ptr.kind = reg_type_e'(data[TYPE_BIT]);
    end
  end

  assign w_noise_hit = w_accept & is_noise(w_ptr);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr        <= '{ch: 2'd0, kind: REG_TONE};
      r_noise      <= 3'd0;
      r_reset_lfsr <= 1'b0;
    end else begin
      r_reset_lfsr <= w_noise_hit;
      if (w_accept && w_is_latch) begin
        r_ptr <= w_ptr;
      end
      if (w_noise_hit) begin
        r_noise <= data[2:0];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tone
      logic [COUNTER_BITS-1:0] r_tone;
      // Bits above 9 are never written, so they stay at their reset zero.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_tone <= '0;
        end else if (w_accept && (w_ptr.ch == 2'(gi)) && (w_ptr.kind == REG_TONE)) begin
          if (w_is_latch) begin
            r_tone[3:0] <= data[3:0];
          end else begin
            r_tone[9:4] <= data[5:0];
          end
        end
      end
      assign w_tone[gi] = r_tone;
    end

    for (gi = 0; gi < 4; gi++) begin : g_attn
      logic [ATTN_BITS-1:0] r_attn;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_attn <= ATTN_BITS'(ATTN_SILENT);
        end else if (w_accept && (w_ptr.ch == 2'(gi)) && (w_ptr.kind == REG_VOLUME)) begin
          r_attn <= ATTN_BITS'(data[3:0]);
        end
      end
      assign w_attn[gi] = r_attn;
    end
  endgenerate

  assign ready         = w_ready;
  assign tone_freq0    = w_tone[0];
  assign tone_freq1    = w_tone[1];
  assign tone_freq2    = w_tone[2];
  assign attn0         = w_attn[0];
  assign attn1         = w_attn[1];
  assign attn2         = w_attn[2];
  assign attn3         = w_attn[3];
  assign noise_control = r_noise;
  assign reset_lfsr    = r_reset_lfsr;

endmodule

// File: tb/tb_psg_register_control.sv
// Bench for psg_register_control: table of byte writes with hand-derived
// register results, plus sequences for reset, busy hold and reset mid-busy.
module tb_psg_register_control;

  localparam int CB = 10;
  localparam int AB = 4;
  localparam int RC = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    data;
  logic          wr_en;
  logic          ready;
  logic [CB-1:0] tone_freq0, tone_freq1, tone_freq2;
  logic [AB-1:0] attn0, attn1, attn2, attn3;
  logic [2:0]    noise_control;
  logic          reset_lfsr;

  psg_register_control #(
    .COUNTER_BITS(CB),
    .ATTN_BITS   (AB),
    .READY_CYCLES(RC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data         (data),
    .wr_en        (wr_en),
    .ready        (ready),
    .tone_freq0   (tone_freq0),
    .tone_freq1   (tone_freq1),
    .tone_freq2   (tone_freq2),
    .attn0        (attn0),
    .attn1        (attn1),
    .attn2        (attn2),
    .attn3        (attn3),
    .noise_control(noise_control),
    .reset_lfsr   (reset_lfsr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0][9:0] tone;
    logic [3:0][3:0] attn;
    logic [2:0]      noise;
    logic            pulse;
  } state_t;

  // sel: 0..2 tone_freqN, 3..6 attn0..3, 7 noise_control
  typedef struct {
    logic [7:0] data;
    int         sel;
    logic [9:0] val;
    logic       pulse;
  } vec_t;

  vec_t   vecs[15];
  state_t exp_q[$];
  state_t cur;
  state_t rst_state;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic compare_state(input string tag);
    state_t e;
    e = exp_q.pop_front();
    chk({tag, " tone_freq0"}, 32'(tone_freq0), 32'(e.tone[0]));
    chk({tag, " tone_freq1"}, 32'(tone_freq1), 32'(e.tone[1]));
    chk({tag, " tone_freq2"}, 32'(tone_freq2), 32'(e.tone[2]));
    chk({tag, " attn0"}, 32'(attn0), 32'(e.attn[0]));
    chk({tag, " attn1"}, 32'(attn1), 32'(e.attn[1]));
    chk({tag, " attn2"}, 32'(attn2), 32'(e.attn[2]));
    chk({tag, " attn3"}, 32'(attn3), 32'(e.attn[3]));
    chk({tag, " noise_control"}, 32'(noise_control), 32'(e.noise));
    chk({tag, " reset_lfsr"}, 32'(reset_lfsr), 32'(e.pulse));
    $display("txn %s: tone=%h/%h/%h attn=%h/%h/%h/%h noise=%b lfsr=%b", tag,
             tone_freq0, tone_freq1, tone_freq2, attn0, attn1, attn2, attn3,
             noise_control, reset_lfsr);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready wait timeout", 32'(ready), 32'd1);
  endtask

  task automatic do_write(input logic [7:0] b, input state_t e, input string tag);
    wait_ready();
    @(negedge clk);
    data  = b;
    wr_en = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    compare_state(tag);
    chk({tag, " ready low after accept"}, 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, " reset_lfsr one cycle"}, 32'(reset_lfsr), 32'd0);
  endtask

  initial begin
    int  low_cnt;
    bit  seen_ready;
    bit  done_accept;

    vecs[0]  = '{8'h8E, 0, 10'h00E, 1'b0};
    vecs[1]  = '{8'h2A, 0, 10'h2AE, 1'b0};
    vecs[2]  = '{8'hE5, 7, 10'h005, 1'b1};
    vecs[3]  = '{8'h03, 7, 10'h003, 1'b1};
    vecs[4]  = '{8'hF7, 6, 10'h007, 1'b0};
    vecs[5]  = '{8'hB0, 4, 10'h000, 1'b0};
    vecs[6]  = '{8'h06, 4, 10'h006, 1'b0};
    vecs[7]  = '{8'hC3, 2, 10'h003, 1'b0};
    vecs[8]  = '{8'h7F, 2, 10'h3F3, 1'b0};
    vecs[9]  = '{8'hA5, 1, 10'h005, 1'b0};
    vecs[10] = '{8'h40, 1, 10'h005, 1'b0};
    vecs[11] = '{8'hEF, 7, 10'h007, 1'b1};
    vecs[12] = '{8'hD9, 5, 10'h009, 1'b0};
    vecs[13] = '{8'h9A, 3, 10'h00A, 1'b0};
    vecs[14] = '{8'hE0, 7, 10'h000, 1'b1};

    rst_state.tone  = '0;
    rst_state.attn  = {4'hF, 4'hF, 4'hF, 4'hF};
    rst_state.noise = 3'd0;
    rst_state.pulse = 1'b0;

    // Reset with a write strobe present: the byte must be dropped.
    reset = 1'b1;
    wr_en = 1'b1;
    data  = 8'h9A;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(rst_state);
    compare_state("reset");
    chk("reset ready", 32'(ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(rst_state);
    compare_state("post-reset");

    cur = rst_state;
    for (int i = 0; i < 15; i++) begin
      cur.pulse = vecs[i].pulse;
      if (vecs[i].sel < 3)       cur.tone[vecs[i].sel] = vecs[i].val;
      else if (vecs[i].sel < 7)  cur.attn[vecs[i].sel - 3] = vecs[i].val[3:0];
      else                       cur.noise = vecs[i].val[2:0];
      do_write(vecs[i].data, cur, $sformatf("vec%0d wr %h", i, vecs[i].data));
    end
    cur.pulse = 1'b0;

    // Busy hold: wr_en stays high with 8'h9F throughout the busy window.
    wait_ready();
    @(negedge clk);
    data  = 8'h90;
    wr_en = 1'b1;
    cur.attn[0] = 4'h0;
    exp_q.push_back(cur);
    @(posedge clk);
    #1;
    compare_state("busy first wr 90");
    data        = 8'h9F;
    low_cnt     = (ready === 1'b0) ? 1 : 0;
    seen_ready  = 1'b0;
    done_accept = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (!seen_ready) begin
        if (ready === 1'b0) begin
          low_cnt++;
          chk("attn0 held while busy", 32'(attn0), 32'h0);
        end else begin
          seen_ready = 1'b1;
        end
      end else if (!done_accept) begin
        done_accept = 1'b1;
        cur.attn[0] = 4'hF;
        exp_q.push_back(cur);
        compare_state("busy held wr 9F");
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("busy low cycles", 32'(low_cnt), 32'(RC));
    chk("busy ready returned", 32'(seen_ready), 32'd1);
    chk("busy held byte accepted", 32'(done_accept), 32'd1);

    // Reset five cycles into BUSY.
    cur.tone[2] = 10'h3F1;
    do_write(8'hC1, cur, "midbusy wr C1");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midbusy reset ready", 32'(ready), 32'd1);
    exp_q.push_back(rst_state);
    compare_state("midbusy reset");
    @(negedge clk);
    reset = 1'b0;
    cur = rst_state;
    cur.tone[0] = 10'h050;
    do_write(8'h05, cur, "after reset wr 05");

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/psg_register_control.md
Name: psg_register_control

Overview:
- Host-side register file and write sequencer for the SN76489-style PSG core.
- Decodes the chip's single-byte latch/data write protocol and holds the three tone periods, four attenuations and the 3-bit noise control.
- Drives the noise generator: `noise_control` goes to the noise control decoder, `tone_freq2` is the rate source for noise rate 3, and `reset_lfsr` restarts the LFSR.
- Models the chip's READY handshake: after each accepted byte the block is busy for a fixed number of cycles.

Parameters:
- COUNTER_BITS, 10, width of each tone period register.
- ATTN_BITS, 4, width of each attenuation register.
- READY_CYCLES, 32, number of cycles `ready` stays low after an accepted write (minimum 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- data  in  8  host write byte.
- wr_en  in  1  write strobe; a byte is accepted when wr_en=1 and ready=1 in the same cycle.
- ready  out  1  1 = can accept a byte; 0 = busy.
- tone_freq0, tone_freq1, tone_freq2  out  COUNTER_BITS each  tone period registers.
- attn0, attn1, attn2, attn3  out  ATTN_BITS each  attenuation; channel 3 is noise.
- noise_control  out  3  {FB, NF1, NF0}.
- reset_lfsr  out  1  one-cycle pulse after any noise-register write.

Behaviour:
- Reset values (applied on the clock edge with reset=1):
  - tone_freqN = 0, attnN = 4'hF (silent), noise_control = 0.
  - reset_lfsr = 0, ready = 1, busy counter = 0.
  - latched register pointer = {ch=0, type=tone}.
- Reset has priority over a simultaneous wr_en; the byte is dropped.
- Latch byte (data[7]=1):
  - Pointer <= {ch=data[6:5], type=data[4]}.
  - Register write, by pointer:
    - tone, ch 0-2: tone_freqN[3:0] <= data[3:0]; bits 9:4 are kept.
    - volume, any ch: attnN <= data[3:0].
    - noise (ch3, type tone): noise_control <= data[2:0]; data[3] is ignored.
- Data byte (data[7]=0): the pointer is unchanged, and the register it selects is written as follows.
  - tone, ch 0-2: tone_freqN[9:4] <= data[5:0]; data[6] is ignored.
  - volume: attnN <= data[3:0].
  - noise: noise_control <= data[2:0].
- Register updates are visible one cycle after the accepting edge.
- LFSR restart:
  - Any accepted write that lands on the noise register asserts reset_lfsr for exactly one cycle.
  - The pulse is in the same cycle that the new noise_control becomes visible.
  - A latch byte with type=volume on ch3 writes attn3 only and does not pulse reset_lfsr.
- Handshake state machine (IDLE, BUSY):
  - IDLE: ready=1. On an accepted write: counter <= READY_CYCLES-1, go to BUSY.
  - BUSY: ready=0. Counter decrements each cycle. When the counter is 0, go to IDLE.
  - Net effect: ready is low for exactly READY_CYCLES cycles after the accepting edge.
- wr_en while ready=0: the byte is ignored, with no register, pointer or counter change. wr_en held high is accepted again on the first cycle ready=1.
- Width rules:
  - Tone registers are COUNTER_BITS wide. With COUNTER_BITS>10 the upper bits stay 0; data bytes fill bits 9:4 only.
  - Period 0 is stored unmodified; its interpretation belongs to the tone/noise generators.
- All outputs are registered; there are no combinational paths from data or wr_en to any output.

Decomposition:
- Shared package psg_pkg holds:
  - Protocol constants: LATCH_BIT=7, CH_MSB=6, CH_LSB=5, TYPE_BIT=4.
  - Register type enum: REG_TONE=0, REG_VOLUME=1.
  - Channel index constant NOISE_CH=3.
  - Reset constant ATTN_SILENT=4'hF.
- One natural sub-module: psg_ready_timer, the IDLE/BUSY counter. Its interface is an accept input and a ready output.
- Byte decode and register file stay in the top module.

Test Plan:
- Reset:
  - Stimulus: reset high 2 cycles, then low.
  - Required: all tone_freq = 0, all attn = F, noise_control = 0, ready = 1, reset_lfsr = 0; with wr_en=1 and data=8'h9A during reset, nothing is written.
- Tone 10-bit write:
  - Stimulus: write 8'h8E, wait for ready, write 8'h2A.
  - Required: tone_freq0 = 10'h00E after the first byte, 10'h2AE after the second; other registers unchanged.
- Noise write:
  - Stimulus: write 8'hE5.
  - Required: noise_control = 3'b101 and a single-cycle reset_lfsr pulse in the same cycle.
  - Then write 8'h03: noise_control = 3'b011 and a second pulse.
  - Then write 8'hF7: attn3 = 7 and no pulse.
- Volume via data byte:
  - Stimulus: write 8'hB0, then 8'h06.
  - Required: attn1 = 0, then attn1 = 6; tone_freq1 unchanged.
- Busy handshake:
  - Stimulus: accept a byte; hold wr_en=1 with data=8'h9F for the next 40 cycles.
  - Required: ready is low for exactly 32 cycles; no write occurs during that time; 8'h9F is accepted on the first ready cycle, giving attn0 = F.
- Reset mid-busy:
  - Stimulus: assert reset 5 cycles into BUSY.
  - Required: ready = 1 on the next cycle, the pointer returns to ch0 tone, and a following 8'h05 writes tone_freq0[9:4] = 5.
